// File: rtl/misc_pkg.sv
// Shared handshake definitions for the toggle req/ack CDC channel.
// Used by both the transmit and the receive side.
package misc_pkg;

    typedef enum logic [1:0] {
        HS_ALIGN,
        HS_IDLE,
        HS_WAIT
    } hs_state_t;

    localparam int HS_SYNC_STAGES = 2;

    // Keeps the timer at least one bit wide when the timeout check is disabled.
    function automatic int hs_timer_w(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop level synchronizer for signals arriving from another clock domain.
module cdc_sync #(
    parameter int DATA_WIDTH = 1,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [STAGES-1:0][DATA_WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 2-phase toggle req/ack CDC channel: holds one word on
// tx_data, flips tx_req per word and waits for the far side's ack toggle.
module cdc_handshake_tx
    import misc_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  ack_async,
    output logic                  ack_done,
    output logic                  err_timeout
);

    localparam int TW = hs_timer_w(TIMEOUT_CYCLES);
    localparam int SW = $clog2(HS_SYNC_STAGES + 1);
    localparam logic          TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    // From reset the synchronizer itself must refill before ack_s is trusted;
    // a re-align from IDLE only needs the shorter settle window.
    localparam logic [SW-1:0] SETTLE_DONE    = SW'(HS_SYNC_STAGES);
    localparam logic [SW-1:0] SETTLE_REALIGN = SW'(HS_SYNC_STAGES - 1);

    hs_state_t             state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ack_s;

    cdc_sync #(
        .DATA_WIDTH (1),
        .STAGES     (HS_SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ack_async),
        .q_o   (ack_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HS_ALIGN;
            settle_q <= '0;
            timer_q  <= '0;
            req_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            timer_q  <= timer_d;
            req_q    <= req_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        timer_d  = timer_q;
        req_d    = req_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            HS_ALIGN: begin
                if (settle_q == SETTLE_DONE) begin
                    req_d    = ack_s;
                    settle_d = '0;
                    state_d  = HS_IDLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            HS_IDLE: begin
                // A word offered while in_ready is high is always taken, so a
                // phase mismatch is only treated as spurious on idle cycles.
                if (in_valid) begin
                    data_d  = in_data;
                    req_d   = ~req_q;
                    timer_d = '0;
                    state_d = HS_WAIT;
                end else if (ack_s != req_q) begin
                    settle_d = SETTLE_REALIGN;
                    state_d  = HS_ALIGN;
                end
            end
            HS_WAIT: begin
                if (ack_s == req_q) begin
                    done_d  = 1'b1;
                    state_d = HS_IDLE;
                end else if (TMO_EN && (timer_q != TMO_MAX)) begin
                    timer_d = timer_q + TW'(1);
                    err_d   = (timer_q == TMO_LAST);
                end
            end
            default: state_d = HS_ALIGN;
        endcase
    end

    assign in_ready    = (state_q == HS_IDLE);
    assign tx_req      = req_q;
    assign tx_data     = data_q;
    assign ack_done    = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed scenarios with literal expectations plus
// randomized traffic against a cycle-level behavioural model and a far-side responder.
module tb_cdc_handshake_tx;

    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          tx_req;
    logic [DW-1:0] tx_data;
    logic          ack_async = 1'b0;
    logic          ack_done;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .ack_async   (ack_async),
        .ack_done    (ack_done),
        .err_timeout (err_timeout)
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Outputs are derived from the protocol rules: a word is owned from accept
    // until the ack level (seen two samples late) equals the request level.
    bit            m_busy, m_req, m_done, m_err;
    logic [DW-1:0] m_data;
    int            m_settle, m_waited;
    bit            h0, h1;
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] rx_q[$];

    always @(posedge clk) begin : model
        bit acks;
        if (rst) begin
            m_busy = 0; m_req = 0; m_data = '0; m_done = 0; m_err = 0;
            m_settle = 3; m_waited = 0; h0 = 0; h1 = 0;
        end else begin
            acks = h1; h1 = h0; h0 = ack_async;
            m_done = 0; m_err = 0;
            if (m_busy) begin
                if (acks == m_req) begin
                    m_busy = 0; m_done = 1;
                end else if (m_waited < TMO) begin
                    m_waited++;
                    m_err = (m_waited == TMO);
                end
            end else if (m_settle > 0) begin
                m_settle--;
                if (m_settle == 0) m_req = acks;
            end else if (in_valid) begin
                sent_q.push_back(in_data);
                m_data = in_data; m_req = !m_req; m_busy = 1; m_waited = 0;
            end else if (acks != m_req) begin
                m_settle = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 32'(in_ready), 0);
            chk("rst_req",   32'(tx_req), 0);
            chk("rst_data",  32'(tx_data), 0);
            chk("rst_done",  32'(ack_done), 0);
            chk("rst_err",   32'(err_timeout), 0);
        end else begin
            chk("ready", 32'(in_ready), 32'(!m_busy && m_settle == 0));
            chk("req",   32'(tx_req), 32'(m_req));
            chk("data",  32'(tx_data), 32'(m_data));
            chk("done",  32'(ack_done), 32'(m_done));
            chk("err",   32'(err_timeout), 32'(m_err));
        end
    end

    int   toggles = 0;
    int   dones = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst && tx_req !== prev_req) toggles++;
        if (!rst && ack_done) dones++;
        prev_req = tx_req;
    end

    // ---------------- far-side responder ----------------
    bit resp_en = 0;
    bit resp_rand = 0;
    int resp_cnt = 0;
    int resp_dly = 4;

    function automatic int pick_dly();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(17, 24));
        return int'($urandom_range(0, 5));
    endfunction

    initial forever begin
        @(posedge clk); #1;
        if (resp_en && !rst) begin
            if (tx_req != ack_async) begin
                if (resp_cnt >= resp_dly) begin
                    rx_q.push_back(tx_data);
                    ack_async = tx_req;
                    resp_cnt = 0;
                    if (resp_rand) resp_dly = pick_dly();
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input bit ack_lvl);
        rst = 1'b1; in_valid = 1'b0; ack_async = ack_lvl;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        for (int i = 0; i < limit && !in_ready; i++) tick();
        chk("wait_ready_bound", 32'(in_ready), 1);
    endtask

    task automatic check_align3(input string tag, input bit req_exp);
        tick(); chk({tag, "_ready_c1"}, 32'(in_ready), 0);
        tick(); chk({tag, "_ready_c2"}, 32'(in_ready), 0);
        tick(); chk({tag, "_ready_c3"}, 32'(in_ready), 1);
        chk({tag, "_req"}, 32'(tx_req), 32'(req_exp));
        chk({tag, "_data"}, 32'(tx_data), 0);
    endtask

    initial begin
        int n, d0, errs, first;

        // 1: reset with ack low
        do_reset(1'b0);
        check_align3("t1", 1'b0);

        // 2: single word, manual ack five cycles later
        in_data = 8'hA5; in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("t2_req", 32'(tx_req), 1);
        chk("t2_data", 32'(tx_data), 32'hA5);
        chk("t2_ready", 32'(in_ready), 0);
        tick(4); ack_async = 1'b1;
        tick(2); chk("t2_done_early", 32'(ack_done), 0);
        tick();  chk("t2_done", 32'(ack_done), 1);
        chk("t2_ready_at_done", 32'(in_ready), 1);
        tick();  chk("t2_done_pulse", 32'(ack_done), 0);

        // 3: back-to-back words with a 4-cycle responder
        sent_q.delete(); rx_q.delete();
        n = toggles; resp_dly = 4; resp_cnt = 0; resp_en = 1;
        for (int w = 1; w <= 3; w++) begin
            in_data = DW'(w); in_valid = 1'b1;
            wait_ready(100);
            tick();
        end
        in_valid = 1'b0;
        wait_ready(100);
        tick();
        resp_en = 0;
        chk("t3_toggles", 32'(toggles - n), 3);
        chk("t3_count", 32'(rx_q.size()), 3);
        for (int i = 0; i < rx_q.size() && i < 3; i++)
            chk($sformatf("t3_word%0d", i), 32'(rx_q[i]), 32'(i + 1));

        // 4: no ack -> single timeout pulse, then a late ack
        in_data = 8'h5C; in_valid = 1'b1; tick(); in_valid = 1'b0;
        errs = 0; first = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (err_timeout) begin
                errs++;
                if (first < 0) first = k;
            end
        end
        chk("t4_err_cycle", 32'(first), 16);
        chk("t4_err_count", 32'(errs), 1);
        chk("t4_ready", 32'(in_ready), 0);
        ack_async = ~ack_async;
        tick(3);
        chk("t4_late_done", 32'(ack_done), 1);
        chk("t4_late_err", 32'(err_timeout), 0);

        // 5: reset with ack high, then a spurious toggle while idle
        d0 = dones;
        do_reset(1'b1);
        tick(3);
        chk("t5_ready", 32'(in_ready), 1);
        chk("t5_req", 32'(tx_req), 1);
        ack_async = 1'b0;
        tick(2); chk("t5_ready_hold", 32'(in_ready), 1);
        tick();  chk("t5_realign_c1", 32'(in_ready), 0);
        tick();  chk("t5_realign_c2", 32'(in_ready), 0);
        tick();  chk("t5_ready_back", 32'(in_ready), 1);
        chk("t5_req_back", 32'(tx_req), 0);
        chk("t5_no_done", 32'(dones - d0), 0);

        // 6: reset in the middle of a wait
        in_data = 8'h3C; in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("t6_req", 32'(tx_req), 1);
        tick(3);
        rst = 1'b1; #1;
        chk("t6_rst_req", 32'(tx_req), 0);
        chk("t6_rst_ready", 32'(in_ready), 0);
        chk("t6_rst_data", 32'(tx_data), 0);
        tick(2); rst = 1'b0;
        check_align3("t6", 1'b0);

        // randomized traffic with random ack delays (some past the timeout)
        sent_q.delete(); rx_q.delete();
        resp_rand = 1; resp_dly = pick_dly(); resp_cnt = 0; resp_en = 1;
        repeat (3000) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_ready(200);
        tick(2);
        resp_en = 0;
        chk("rand_nonempty", 32'(sent_q.size() > 0), 1);
        chk("rand_count", 32'(rx_q.size()), 32'(sent_q.size()));
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk($sformatf("rand_word%0d", i), 32'(rx_q[i]), 32'(sent_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
